// File: rtl/ahb_tone_pkg.sv
// ahb_tone_pkg: register map indices and default widths for the AHB tone generator
package ahb_tone_pkg;
    localparam int DEF_NCHAN = 2;
    localparam int DEF_DIV_W = 16;
    localparam int DEF_LEN_W = 16;
    localparam int DIV_OFS   = 0;
    localparam int LEN_OFS   = 1;
    function automatic int status_idx(input int nchan);
        return 2 * nchan;
    endfunction
    function automatic int irqen_idx(input int nchan);
        return 2 * nchan + 1;
    endfunction
endpackage

// File: rtl/ahb_tone_gen_channel.sv
// tone_channel: one square-wave channel with exact half-period divider and note-length counter
module tone_channel #(
    parameter int DIV_W = 16,
    parameter int LEN_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             div_wr,
    input  logic             len_wr,
    input  logic             done_clr,
    input  logic [31:0]      wdata,
    output logic             aud,
    output logic             done,
    output logic             busy,
    output logic [DIV_W-1:0] div_q,
    output logic [LEN_W-1:0] rem_q
);
    logic [DIV_W-1:0] cnt;
    logic             tick, note_end, unused_w;
    assign unused_w = &{1'b0, wdata};
    assign busy     = div_q != '0;
    assign tick     = busy && cnt == div_q - DIV_W'(1);
    assign note_end = tick && !div_wr && !len_wr && rem_q == LEN_W'(1);
    // divider, output toggle and note countdown; bus writes take priority over a toggle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            rem_q <= '0;
            cnt   <= '0;
            aud   <= 1'b0;
            done  <= 1'b0;
        end else begin
            if (div_wr) begin
                div_q <= wdata[DIV_W-1:0];
                cnt   <= '0;
                aud   <= 1'b0;
            end else if (busy) begin
                cnt <= tick ? '0 : cnt + DIV_W'(1);
                if (note_end) begin
                    div_q <= '0;
                    aud   <= 1'b0;
                end else if (tick && !len_wr) aud <= ~aud;
            end
            if (len_wr) rem_q <= wdata[LEN_W-1:0];
            else if (tick && !div_wr && rem_q != '0) rem_q <= rem_q - LEN_W'(1);
            done <= note_end || (done && !done_clr && !len_wr);
        end
    end
endmodule

// File: rtl/ahb_tone_gen.sv
// ahb_tone_gen: AHB-Lite slave with NCHAN square-wave tone channels and a level interrupt
module ahb_tone_gen
    import ahb_tone_pkg::*;
#(
    parameter int NCHAN = DEF_NCHAN,
    parameter int DIV_W = DEF_DIV_W,
    parameter int LEN_W = DEF_LEN_W
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic             HREADY,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic [31:0]      HWDATA,
    output logic [31:0]      HRDATA,
    output logic             HREADYOUT,
    output logic [NCHAN-1:0] Audiout,
    output logic             IRQ
);
    logic [3:0]                  idx;
    logic                        wr, rd, sts_wr, unused_ok;
    logic [NCHAN-1:0]            irq_en, done, busy, div_wr, len_wr, done_clr;
    logic [NCHAN-1:0][DIV_W-1:0] div_q;
    logic [NCHAN-1:0][LEN_W-1:0] rem_q;
    assign unused_ok = &{1'b0, HADDR[31:6], HADDR[1:0], HTRANS[0], HWDATA};
    assign HREADYOUT = 1'b1;
    assign sts_wr    = wr && int'(idx) == status_idx(NCHAN);
    assign IRQ       = |(done & irq_en);
    for (genvar c = 0; c < NCHAN; c++) begin : g_ch
        assign div_wr[c]   = wr && int'(idx) == 2 * c + DIV_OFS;
        assign len_wr[c]   = wr && int'(idx) == 2 * c + LEN_OFS;
        assign done_clr[c] = sts_wr && HWDATA[NCHAN+c];
        tone_channel #(.DIV_W(DIV_W), .LEN_W(LEN_W)) u_ch (
            .clk(HCLK), .rst_n(HRESETn), .div_wr(div_wr[c]), .len_wr(len_wr[c]),
            .done_clr(done_clr[c]), .wdata(HWDATA), .aud(Audiout[c]), .done(done[c]),
            .busy(busy[c]), .div_q(div_q[c]), .rem_q(rem_q[c])
        );
    end
    // address-phase capture and interrupt-enable register
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            idx    <= '0;
            wr     <= 1'b0;
            rd     <= 1'b0;
            irq_en <= '0;
        end else begin
            if (HREADY) begin
                idx <= HADDR[5:2];
                wr  <= HSEL && HWRITE && HTRANS[1];
                rd  <= HSEL && !HWRITE && HTRANS[1];
            end
            if (wr && int'(idx) == irqen_idx(NCHAN)) irq_en <= HWDATA[NCHAN-1:0];
        end
    end
    // read mux driven from the registered word index
    always_comb begin
        HRDATA = '0;
        if (rd) begin
            for (int c = 0; c < NCHAN; c++) begin
                if (int'(idx) == 2 * c + DIV_OFS) HRDATA[DIV_W-1:0] = div_q[c];
                if (int'(idx) == 2 * c + LEN_OFS) HRDATA[LEN_W-1:0] = rem_q[c];
            end
            if (int'(idx) == status_idx(NCHAN)) HRDATA[2*NCHAN-1:0] = {done, busy};
            if (int'(idx) == irqen_idx(NCHAN)) HRDATA[NCHAN-1:0] = irq_en;
        end
    end
endmodule
